aes_sched_arb: RTL and testbench

Two-requester scheduler for the single `AES_top` encryption core. It accepts plaintext/key blocks from two independent valid/ready request ports and arbitrates between them round-robin. It sequences the core's `AES_en` / data / key inputs for exactly one block at a time, then returns the ciphertext on one tagged response port. A cycle watchdog guards against a core that never raises `AES_data_out_valid`.

---
 rtl/aes_sched_arb_pkg.sv | 14 +
 rtl/aes_sched_arb_if.sv | 45 ++++
 rtl/aes_sched_arb_rr_arb2.sv | 21 ++
 rtl/aes_sched_arb.sv | 96 +++++++++
 tb/tb_aes_sched_arb.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sched_arb_pkg.sv
// Shared types and constants for the two-requester AES core scheduler.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int REQ_IDX_W = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/aes_sched_arb_if.sv
// Request, response and core-facing signals of the AES scheduler.
// Handshakes are valid/ready: a transfer happens on the rising edge where both are high;
// a producer holds valid and its payload stable until that edge, and never waits on ready to raise valid.
interface aes_sched_arb_if;
  import aes_pkg::*;

  logic                 req0_valid;
  logic                 req0_ready;
  logic [AES_BLK_W-1:0] req0_data;
  logic [AES_BLK_W-1:0] req0_key;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [AES_BLK_W-1:0] req1_data;
  logic [AES_BLK_W-1:0] req1_key;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [REQ_IDX_W-1:0] rsp_id;
  logic                 rsp_err;
  logic [AES_BLK_W-1:0] rsp_data;

  logic                 core_en;
  logic [AES_BLK_W-1:0] core_data_in;
  logic [AES_BLK_W-1:0] core_key_in;
  logic [AES_BLK_W-1:0] core_data_out;
  logic                 core_data_out_valid;

  logic                 busy;
  state_e               state_dbg;

  modport master (
    output req0_valid, req0_data, req0_key, req1_valid, req1_data, req1_key,
    output rsp_ready, core_data_out, core_data_out_valid,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
    input  core_en, core_data_in, core_key_in, busy, state_dbg
  );

  modport slave (
    input  req0_valid, req0_data, req0_key, req1_valid, req1_data, req1_key,
    input  rsp_ready, core_data_out, core_data_out_valid,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
    output core_en, core_data_in, core_key_in, busy, state_dbg
  );

endinterface

// File: rtl/aes_sched_arb_rr_arb2.sv
// Two-way round-robin grant: a lone request wins; on a tie the side not granted last time wins.
module aes_rr_arb2
  import aes_pkg::*;
(
  input  logic [1:0]           valid,
  input  logic [REQ_IDX_W-1:0] last_grant,
  output logic                 gnt_valid,
  output logic [REQ_IDX_W-1:0] gnt_id
);

  always_comb begin
    gnt_valid = |valid;
    gnt_id    = '0;
    if (valid == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (valid[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/aes_sched_arb.sv
// Schedules blocks from two requesters onto one AES core, one block at a time,
// with a saturating watchdog that turns a silent core into an error response.
module aes_sched_arb
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic           AES_clk,
  input  logic           AES_rst_n,
  aes_sched_arb_if.slave bus
);

  state_e               state_q, state_d;
  logic [REQ_IDX_W-1:0] last_grant_q, id_q, gnt_id;
  logic                 gnt_valid, accept, timeout;
  logic [CNT_W-1:0]     wdog_q;
  logic [AES_BLK_W-1:0] data_q, key_q, rsp_data_q;
  logic                 rsp_err_q;

  aes_rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign accept  = (state_q == IDLE) && gnt_valid;
  assign timeout = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (bus.core_data_out_valid || timeout) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= '0;
      data_q       <= '0;
      key_q        <= '0;
      wdog_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q       <= (gnt_id == '0) ? bus.req0_data : bus.req1_data;
            key_q        <= (gnt_id == '0) ? bus.req0_key  : bus.req1_key;
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            wdog_q       <= '0;
          end
        end
        RUN: begin
          if (wdog_q != '1) wdog_q <= wdog_q + CNT_W'(1);
          // A result arriving on the timeout cycle still counts as success.
          if (bus.core_data_out_valid) begin
            rsp_data_q <= bus.core_data_out;
            rsp_err_q  <= 1'b0;
          end else if (timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready   = accept && (gnt_id == '0);
  assign bus.req1_ready   = accept && (gnt_id != '0);
  assign bus.core_en      = (state_q == RUN);
  assign bus.core_data_in = data_q;
  assign bus.core_key_in  = key_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_aes_sched_arb.sv
// Bench for aes_sched_arb: AES-128 reference core stub, table of single blocks, and
// hand-written sequences for ties, backpressure, timeout, mid-run reset and stray core valids.
module tb_aes_sched_arb;
  import aes_pkg::*;

  localparam int TMO      = 16;
  localparam int CORE_LAT = 5;

  logic AES_clk;
  logic AES_rst_n;
  aes_sched_arb_if bus ();

  aes_sched_arb #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
    .AES_clk   (AES_clk),
    .AES_rst_n (AES_rst_n),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    AES_clk = 1'b0;
    forever #5 AES_clk = ~AES_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [129:0] exp_q[$];
  logic [129:0] mon_e;
  logic [127:0] last_data = '0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: driven by hand

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- AES-128 reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
      for (int i = 0; i < 16; i++) tmp[i] = st[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        st = tmp;
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
    return ct;
  endfunction

  // ---------------- core stub ----------------
  logic         stub_vld  = 1'b0;
  logic [127:0] stub_data = '0;
  logic         spur_vld  = 1'b0;
  logic [127:0] spur_data = '0;
  bit           stub_dead = 1'b0;
  int           stub_cnt  = 0;

  assign bus.core_data_out_valid = stub_vld | spur_vld;
  assign bus.core_data_out       = spur_vld ? spur_data : stub_data;

  always @(negedge AES_clk) begin
    if (bus.core_en && !stub_dead) begin
      stub_cnt = stub_cnt + 1;
      if (stub_cnt == CORE_LAT) begin
        stub_vld  = 1'b1;
        stub_data = aes_enc(bus.core_key_in, bus.core_data_in);
      end else begin
        stub_vld = 1'b0;
      end
    end else begin
      stub_cnt = 0;
      stub_vld = 1'b0;
    end
  end

  // ---------------- response ready driver ----------------
  initial begin
    forever begin
      @(posedge AES_clk);
      #1;
      if (rdy_mode == 0)      bus.rsp_ready = 1'b1;
      else if (rdy_mode == 1) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge AES_clk) begin
    if (AES_rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 256'({1'b1, bus.rsp_id, bus.rsp_err, bus.rsp_data}), 256'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", 256'({bus.rsp_id, bus.rsp_err, bus.rsp_data}), 256'(mon_e));
        last_data = mon_e[127:0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit port, input logic [127:0] key, input logic [127:0] data,
                      input logic [129:0] exp);
    int  g;
    bit  got;
    @(posedge AES_clk); #1;
    if (port) begin bus.req1_valid = 1'b1; bus.req1_key = key; bus.req1_data = data; end
    else      begin bus.req0_valid = 1'b1; bus.req0_key = key; bus.req0_data = data; end
    g = 0; got = 1'b0;
    while (!got && g < 200) begin
      @(negedge AES_clk); g++;
      if (port ? bus.req1_ready : bus.req0_ready) got = 1'b1;
    end
    if (!got) chk("send_wait", 256'(0), 256'(1));
    else      exp_q.push_back(exp);
    @(posedge AES_clk); #1;
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    do begin @(negedge AES_clk); g++; end
    while ((exp_q.size() != 0 || bus.busy) && g < 300);
    if (g >= 300) begin
      chk(name, 256'(1), 256'(0));
      exp_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_ctl"}, 256'({bus.core_en, bus.busy, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                              bus.req0_ready, bus.req1_ready, bus.state_dbg}), 256'(0));
    chk({name, "_rsp_data"}, 256'(bus.rsp_data), 256'(0));
    chk({name, "_core_in"}, 256'({bus.core_data_in, bus.core_key_in}), 256'(0));
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    bit           port;
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [6];
  logic [127:0] tk [2][3];
  logic [127:0] td [2][3];
  int           nxt [2];
  logic [127:0] k, d, ct;
  int           cnt;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0;
    bus.rsp_ready  = 1'b0;
    AES_rst_n = 1'b0;
    build_sbox();

    tbl[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 6; i++) begin
      tbl[i].port = 1'($urandom_range(0, 1));
      tbl[i].key  = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].data = {$urandom, $urandom, $urandom, $urandom};
      tbl[i].exp  = aes_enc(tbl[i].key, tbl[i].data);
    end

    // reset values
    #3;
    check_zero_outputs("reset");
    repeat (2) @(posedge AES_clk);
    #3 AES_rst_n = 1'b1;

    // tie: both requesters held valid, grants must alternate 0,1,0,1
    rdy_mode = 0;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 3; b++) begin
        tk[p][b] = {$urandom, $urandom, $urandom, $urandom};
        td[p][b] = {$urandom, $urandom, $urandom, $urandom};
      end
    nxt[0] = 0; nxt[1] = 0;
    @(posedge AES_clk); #1;
    bus.req0_valid = 1'b1; bus.req0_key = tk[0][0]; bus.req0_data = td[0][0];
    bus.req1_valid = 1'b1; bus.req1_key = tk[1][0]; bus.req1_data = td[1][0];
    for (int n = 0; n < 4; n++) begin
      int g;
      int p;
      g = 0;
      do begin @(negedge AES_clk); g++; end
      while (!(bus.req0_ready || bus.req1_ready) && g < 100);
      if (!(bus.req0_ready || bus.req1_ready)) begin
        chk("tie_wait", 256'(1), 256'(0));
        break;
      end
      p = bus.req1_ready ? 1 : 0;
      chk("tie_grant", 256'({bus.req0_ready, bus.req1_ready}),
          256'(((n % 2) == 0) ? 2'b10 : 2'b01));
      exp_q.push_back({1'(p), 1'b0, aes_enc(tk[p][nxt[p]], td[p][nxt[p]])});
      @(posedge AES_clk); #1;
      nxt[p]++;
      if (p == 0) begin bus.req0_key = tk[0][nxt[0]]; bus.req0_data = td[0][nxt[0]]; end
      else        begin bus.req1_key = tk[1][nxt[1]]; bus.req1_data = td[1][nxt[1]]; end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_done("tie_drain");

    // table of single blocks with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].port, tbl[i].key, tbl[i].data, {tbl[i].port, 1'b0, tbl[i].exp});
      wait_done("table_drain");
    end

    // backpressure: ready low for 20 cycles, then a single-cycle ready; stray valid during GAP
    rdy_mode = 2;
    bus.rsp_ready = 1'b0;
    k = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom, $urandom, $urandom};
    ct = aes_enc(k, d);
    send(1'b0, k, d, {1'b0, 1'b0, ct});
    cnt = 0;
    while (!bus.rsp_valid && cnt < 100) begin @(negedge AES_clk); cnt++; end
    bus.req1_valid = 1'b1;
    bus.req1_key   = tk[1][2];
    bus.req1_data  = td[1][2];
    for (int i = 0; i < 20; i++) begin
      chk("hold_ctl", 256'({bus.rsp_valid, bus.busy, bus.core_en, bus.req0_ready, bus.req1_ready,
                            bus.rsp_id, bus.rsp_err, bus.rsp_data}),
          256'({7'b1100000, ct}));
      @(negedge AES_clk);
    end
    @(posedge AES_clk); #1 bus.rsp_ready = 1'b1;
    @(posedge AES_clk); #1;
    bus.rsp_ready = 1'b0;
    spur_vld  = 1'b1;
    spur_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge AES_clk);
    chk("gap_state", 256'({bus.state_dbg, bus.core_en, bus.busy, bus.rsp_valid, bus.req1_ready}),
        256'({GAP, 4'b0100}));
    @(posedge AES_clk); #1 spur_vld = 1'b0;
    @(negedge AES_clk);
    chk("gap_to_idle", 256'({bus.state_dbg, bus.rsp_valid, bus.req1_ready, bus.rsp_data}),
        256'({IDLE, 2'b01, ct}));
    exp_q.push_back({1'b1, 1'b0, aes_enc(tk[1][2], td[1][2])});
    @(posedge AES_clk); #1 bus.req1_valid = 1'b0;
    rdy_mode = 0;
    wait_done("bp_drain");

    // stray core valid while idle
    @(posedge AES_clk); #1;
    spur_vld  = 1'b1;
    spur_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge AES_clk); #1 spur_vld = 1'b0;
    @(negedge AES_clk);
    chk("idle_spur", 256'({bus.state_dbg, bus.rsp_valid, bus.busy, bus.core_en, bus.rsp_data}),
        256'({IDLE, 3'b000, last_data}));

    // watchdog: silent core, error response TMO edges after accept, then normal service
    stub_dead = 1'b1;
    send(1'b1, tk[0][1], td[0][1], {1'b1, 1'b1, 128'h0});
    cnt = 0;
    forever begin
      @(negedge AES_clk);
      if (bus.rsp_valid || cnt >= 100) break;
      @(posedge AES_clk);
      cnt++;
    end
    chk("timeout_edges", 256'(cnt), 256'(TMO));
    wait_done("timeout_drain");
    stub_dead = 1'b0;
    send(1'b0, tk[1][1], td[1][1], {1'b0, 1'b0, aes_enc(tk[1][1], td[1][1])});
    wait_done("after_timeout_drain");

    // reset mid-RUN: everything drops immediately, no response for the lost block
    send(1'b0, tk[0][2], td[0][2], {1'b0, 1'b0, aes_enc(tk[0][2], td[0][2])});
    repeat (2) @(posedge AES_clk);
    #3;
    chk("pre_rst_run", 256'({bus.state_dbg, bus.core_en}), 256'({RUN, 1'b1}));
    AES_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_zero_outputs("mid_rst");
    repeat (2) @(posedge AES_clk);
    #3 AES_rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge AES_clk);
      if (bus.rsp_valid) cnt++;
    end
    chk("no_rsp_after_rst", 256'(cnt), 256'(0));
    send(1'b1, 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc, 128'h00000065000000000000000000000000,
         {1'b1, 1'b0, aes_enc(128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc,
                              128'h00000065000000000000000000000000)});
    wait_done("post_rst_drain");

    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
